// File: rtl/sqrt_ctrl.sv
//------------------------------------------------------------------------------
// sqrt_ctrl : control FSM for an iterative square-root datapath
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_ctrl #(
    parameter int MAX_ITER = 256,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic             N_o,
    output logic             boot_o,
    output logic             wr_square_o,
    output logic             wr_root_o,
    output logic             muxes_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] iter_o
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOOT   = 3'd1,
        S_CHECK  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q,  iter_d;
    logic             ovf_q,   ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        ovf_d       = ovf_q;
        boot_o      = 1'b0;
        wr_square_o = 1'b0;
        wr_root_o   = 1'b0;
        muxes_o     = 1'b0;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_d = S_BOOT;
            end
            S_BOOT: begin
                boot_o      = 1'b1;
                wr_square_o = 1'b1;
                wr_root_o   = 1'b1;
                busy_o      = 1'b1;
                iter_d      = '0;
                ovf_d       = 1'b0;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                muxes_o = 1'b1;
                busy_o  = 1'b1;
                // A negative result terminates normally even on the last allowed iteration.
                if (N_o) begin
                    state_d = S_DONE;
                end else if (iter_q == C_MAX_CNT) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                wr_square_o = 1'b1;
                wr_root_o   = 1'b1;
                busy_o      = 1'b1;
                iter_d      = iter_q + CNT_W'(1);
                state_d     = S_CHECK;
            end
            S_DONE: begin
                done_o = 1'b1;
                if (ack_i) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ovf_o  = ovf_q;
    assign iter_o = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_ctrl.sv
//------------------------------------------------------------------------------
// tb_sqrt_ctrl : directed and constrained-random checks of the sqrt_ctrl FSM
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sqrt_ctrl;

    localparam int CNT_W = 9;

    // {ready, busy, done, boot, wr_square, wr_root, muxes}
    localparam logic [6:0] C_IDLE  = 7'b1000000;
    localparam logic [6:0] C_BOOT  = 7'b0101110;
    localparam logic [6:0] C_CHECK = 7'b0100001;
    localparam logic [6:0] C_UPD   = 7'b0100110;
    localparam logic [6:0] C_DONE  = 7'b0010000;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             ack_i;
    logic             n_flag;
    logic             boot_o;
    logic             wr_square_o;
    logic             wr_root_o;
    logic             muxes_o;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic             ovf_o;
    logic [CNT_W-1:0] iter_o;
    logic [6:0]       ctl;

    int vectors;
    int errors;

    sqrt_ctrl #(
        .MAX_ITER (256),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .ack_i       (ack_i),
        .N_o         (n_flag),
        .boot_o      (boot_o),
        .wr_square_o (wr_square_o),
        .wr_root_o   (wr_root_o),
        .muxes_o     (muxes_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .iter_o      (iter_o)
    );

    assign ctl = {ready_o, busy_o, done_o, boot_o, wr_square_o, wr_root_o, muxes_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; ack_i = 1'b0; n_flag = 1'b0;
        step();
        step();
        vectors++;
        if (ctl !== C_IDLE || iter_o !== '0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ctl=%b iter=%0d ovf=%b required ctl=%b iter=0 ovf=0",
                     ctl, iter_o, ovf_o, C_IDLE);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (ctl !== C_IDLE || iter_o !== '0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ctl=%b iter=%0d ovf=%b required ctl=%b iter=0 ovf=0",
                     ctl, iter_o, ovf_o, C_IDLE);
        end
    endtask

    // One operation with k UPDATEs; ends parked in DONE with inputs idle.
    // noise drives start_i/ack_i throughout the run; both must be ignored.
    task automatic run_op(input int k, input bit exp_ovf, input bit noise, input string name);
        logic [6:0] exp_ctl;
        int         last;
        last    = 2 * k + 2;
        start_i = 1'b1; ack_i = 1'b0; n_flag = 1'b0;
        step();
        start_i = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c == 0)         exp_ctl = C_BOOT;
            else if (c == last) exp_ctl = C_DONE;
            else if (c % 2)     exp_ctl = C_CHECK;
            else                exp_ctl = C_UPD;
            vectors++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s ctl@%0d: got %b required %b", name, c, ctl, exp_ctl);
            end
            if (c >= 1) begin
                vectors++;
                if (iter_o !== CNT_W'((c - 1) / 2) || ovf_o !== ((c == last) ? exp_ovf : 1'b0)) begin
                    errors++;
                    $display("FAIL %s iter/ovf@%0d: got %0d/%b required %0d/%b", name, c,
                             iter_o, ovf_o, (c - 1) / 2, (c == last) ? exp_ovf : 1'b0);
                end
            end
            n_flag  = !exp_ovf && (c == last - 1);
            start_i = noise && (c < last);
            ack_i   = noise && (c < last);
            if (c < last) step();
        end
        n_flag = 1'b0;
    endtask

    task automatic test_ack(input int exp_iter, input bit exp_ovf);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        vectors++;
        if (ctl !== C_IDLE || iter_o !== CNT_W'(exp_iter) || ovf_o !== exp_ovf) begin
            errors++;
            $display("FAIL ack_idle: ctl=%b iter=%0d ovf=%b required ctl=%b iter=%0d ovf=%b",
                     ctl, iter_o, ovf_o, C_IDLE, exp_iter, exp_ovf);
        end
    endtask

    task automatic test_hold_ack();
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (ctl !== C_DONE || iter_o !== CNT_W'(256) || ovf_o !== 1'b1) begin
                errors++;
                $display("FAIL done_hold@%0d: ctl=%b iter=%0d ovf=%b required ctl=%b iter=256 ovf=1",
                         i, ctl, iter_o, ovf_o, C_DONE);
            end
        end
        ack_i = 1'b1; start_i = 1'b1;
        step();
        ack_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ctl !== C_IDLE || iter_o !== CNT_W'(256) || ovf_o !== 1'b1) begin
                errors++;
                $display("FAIL ack_start_idle@%0d: ctl=%b iter=%0d ovf=%b required ctl=%b iter=256 ovf=1",
                         i, ctl, iter_o, ovf_o, C_IDLE);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_op();
        start_i = 1'b1; n_flag = 1'b0;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (ctl !== C_UPD || iter_o !== CNT_W'(1)) begin
            errors++;
            $display("FAIL abort_setup: ctl=%b iter=%0d required ctl=%b iter=1", ctl, iter_o, C_UPD);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (ctl !== C_IDLE || iter_o !== '0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ctl=%b iter=%0d ovf=%b required ctl=%b iter=0 ovf=0",
                     ctl, iter_o, ovf_o, C_IDLE);
        end
        step();
        vectors++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL abort_stay_idle: ctl=%b required %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_random();
        int   boots;
        int   dones;
        logic done_prev;
        boots = 0; dones = 0; done_prev = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start_i = ($urandom_range(0, 3) == 0);
            ack_i   = ($urandom_range(0, 3) == 0);
            n_flag  = ($urandom_range(0, 3) == 0);
            step();
            vectors++;
            if ((boot_o && muxes_o) ||
                ((wr_square_o || wr_root_o) && (muxes_o || done_o || ready_o)) ||
                (wr_square_o !== wr_root_o) ||
                ($countones({ready_o, busy_o, done_o}) != 1)) begin
                errors++;
                $display("FAIL rand_invariant@%0d: ctl=%b", i, ctl);
            end
            if (boot_o) boots++;
            if (done_o && !done_prev) begin
                dones++;
                vectors++;
                if (boots != 1) begin
                    errors++;
                    $display("FAIL rand_boot_per_done@%0d: got %0d boots required 1", i, boots);
                end
                boots = 0;
            end
            done_prev = done_o;
        end
        start_i = 1'b0; ack_i = 1'b0; n_flag = 1'b0;
        vectors++;
        if (dones < 20) begin
            errors++;
            $display("FAIL rand_activity: got %0d completions required at least 20", dones);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        run_op(0, 1'b0, 1'b0, "op_k0");
        test_ack(0, 1'b0);
        run_op(3, 1'b0, 1'b0, "op_k3");
        test_ack(3, 1'b0);
        run_op(2, 1'b0, 1'b1, "op_k2_noise");
        test_ack(2, 1'b0);
        run_op(256, 1'b1, 1'b0, "op_ovf");
        test_hold_ack();
        run_op(1, 1'b0, 1'b0, "op_after_ovf");
        test_ack(1, 1'b0);
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
